// File: rtl/mult4_partial_product_sequencer_if.sv
// Link between the 4x4 sequencer and the probabilistic 2-bit multiplier stage.
// The sequencer uses the master side; the 2-bit multiplier (or a bench responder) uses the slave side.
interface mult4_partial_product_sequencer_if;
    logic       sub_mode;
    logic       sub_valid_in;
    logic [1:0] sub_in1;
    logic [1:0] sub_in2;
    logic [3:0] sub_op;
    logic       sub_valid_res;
    logic [3:0] sub_res;

    modport master (
        output sub_mode,
        output sub_valid_in,
        output sub_in1,
        output sub_in2,
        output sub_op,
        input  sub_valid_res,
        input  sub_res
    );

    modport slave (
        input  sub_mode,
        input  sub_valid_in,
        input  sub_in1,
        input  sub_in2,
        input  sub_op,
        output sub_valid_res,
        output sub_res
    );
endinterface

// File: rtl/mult4_partial_product_sequencer.sv
// 4x4 multiplier built from four 2x2 partial products, issued one at a time to an external
// 2-bit stage. The returned results are shifted and accumulated. A watchdog aborts any partial product that never returns.
module mult4_partial_product_sequencer #(
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int TW             = 12
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       MODE,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product,
    output logic       timeout_err,
    mult4_partial_product_sequencer_if.master sub
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [3:0]    a_q, a_d;
    logic [3:0]    b_q, b_d;
    logic [7:0]    acc_q, acc_d;
    logic [1:0]    k_q, k_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    product_q, product_d;
    logic          err_q, err_d;
    logic          vin_q, vin_d;
    logic [1:0]    in1_q, in1_d;
    logic [1:0]    in2_q, in2_d;

    logic [TW-1:0] cnt_inc;
    logic [7:0]    acc_sum;
    logic [1:0]    k_next;

    // k[0] picks the upper half of a, k[1] the upper half of b.
    function automatic logic [3:0] pp_operands(input logic [1:0] k,
                                               input logic [3:0] op_a,
                                               input logic [3:0] op_b);
        logic [1:0] x;
        logic [1:0] y;
        x = k[0] ? op_a[3:2] : op_a[1:0];
        y = k[1] ? op_b[3:2] : op_b[1:0];
        return {x, y};
    endfunction

    function automatic logic [7:0] pp_term(input logic [1:0] k, input logic [3:0] res);
        logic [7:0] term;
        case (k)
            2'd0:    term = {4'b0000, res};
            2'd1,
            2'd2:    term = {2'b00, res, 2'b00};
            default: term = {res, 4'b0000};
        endcase
        return term;
    endfunction

    assign cnt_inc = cnt_q + TW'(1);
    assign acc_sum = acc_q + pp_term(k_q, sub.sub_res);
    assign k_next  = k_q + 2'd1;

    always_comb begin
        // NOTE: every target gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        err_d     = err_q;
        vin_d     = 1'b0;
        in1_d     = in1_q;
        in2_d     = in2_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d            = a;
                    b_d            = b;
                    acc_d          = 8'h00;
                    k_d            = 2'd0;
                    {in1_d, in2_d} = pp_operands(2'd0, a, b);
                    vin_d          = 1'b1;
                    busy_d         = 1'b1;
                    state_d        = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                cnt_d = cnt_inc;
                // A result landing on the watchdog's last cycle still counts.
                if (sub.sub_valid_res) begin
                    acc_d = acc_sum;
                    if (k_q == 2'd3) begin
                        done_d    = 1'b1;
                        product_d = acc_sum;
                        err_d     = 1'b0;
                        state_d   = ST_DONE;
                    end else begin
                        k_d            = k_next;
                        {in1_d, in2_d} = pp_operands(k_next, a_q, b_q);
                        vin_d          = 1'b1;
                        state_d        = ST_ISSUE;
                    end
                end else if (cnt_inc == TW'(TIMEOUT_CYCLES)) begin
                    done_d    = 1'b1;
                    product_d = 8'h00;
                    err_d     = 1'b1;
                    state_d   = ST_DONE;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            a_q       <= 4'h0;
            b_q       <= 4'h0;
            acc_q     <= 8'h00;
            k_q       <= 2'd0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= 8'h00;
            err_q     <= 1'b0;
            vin_q     <= 1'b0;
            in1_q     <= 2'd0;
            in2_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
            err_q     <= err_d;
            vin_q     <= vin_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign product      = product_q;
    assign timeout_err  = err_q;

    assign sub.sub_mode     = MODE;
    assign sub.sub_valid_in = vin_q;
    assign sub.sub_in1      = in1_q;
    assign sub.sub_in2      = in2_q;
    assign sub.sub_op       = 4'b0000;

endmodule

// File: tb/tb_mult4_partial_product_sequencer.sv
// Directed bench for the 4x4 partial-product sequencer. A delay-programmable responder answers each request.
// A timing/arithmetic model built from request delays is checked against the outputs every cycle.
module tb_mult4_partial_product_sequencer;

    localparam int TO = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       MODE = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = 4'h0;
    logic [3:0] b = 4'h0;
    logic       busy;
    logic       done;
    logic [7:0] product;
    logic       timeout_err;

    mult4_partial_product_sequencer_if sub_if ();

    mult4_partial_product_sequencer #(.TIMEOUT_CYCLES(TO), .TW(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .MODE        (MODE),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product),
        .timeout_err (timeout_err),
        .sub         (sub_if)
    );

    always #5 CLK = ~CLK;

    longint cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: derived purely from operands and the programmed response delays.
    longint     m_start = -10;
    longint     m_done  = -10;
    longint     m_issue [4] = '{-10, -10, -10, -10};
    logic [3:0] m_a = 4'h0;
    logic [3:0] m_b = 4'h0;
    logic [7:0] pend_prod = 8'h00;
    logic       pend_err  = 1'b0;
    logic [7:0] held_prod = 8'h00;
    logic       held_err  = 1'b0;

    int         resp_delay [4] = '{0, 0, 0, 0};
    int         glitch_k  = -1;
    int         resp_idx  = 0;
    logic [1:0] cap1 [4];
    logic [1:0] cap2 [4];

    initial begin
        sub_if.sub_valid_res = 1'b0;
        sub_if.sub_res       = 4'h0;
    end

    // Responder: answers request idx with the exact 2x2 product after resp_delay[idx] WAIT cycles.
    initial begin
        forever begin
            @(negedge CLK);
            if (sub_if.sub_valid_in) begin
                int idx;
                int d;
                logic [1:0] e1;
                logic [1:0] e2;
                idx = resp_idx;
                resp_idx++;
                if (idx < 4) begin
                    cap1[idx] = sub_if.sub_in1;
                    cap2[idx] = sub_if.sub_in2;
                    case (idx)
                        0:       begin e1 = m_a[1:0]; e2 = m_b[1:0]; end
                        1:       begin e1 = m_a[3:2]; e2 = m_b[1:0]; end
                        2:       begin e1 = m_a[1:0]; e2 = m_b[3:2]; end
                        default: begin e1 = m_a[3:2]; e2 = m_b[3:2]; end
                    endcase
                    check($sformatf("sub_in1_k%0d", idx), 32'(sub_if.sub_in1), 32'(e1));
                    check($sformatf("sub_in2_k%0d", idx), 32'(sub_if.sub_in2), 32'(e2));
                    d = resp_delay[idx];
                    if (idx == glitch_k) begin
                        sub_if.sub_valid_res = 1'b1;
                        sub_if.sub_res       = 4'hF;
                    end
                    if (d >= 0) begin
                        @(posedge CLK);
                        #1;
                        sub_if.sub_valid_res = 1'b0;
                        if (d > 0) begin
                            repeat (d) @(posedge CLK);
                            #1;
                        end
                        sub_if.sub_valid_res = 1'b1;
                        sub_if.sub_res       = 4'(32'(e1) * 32'(e2));
                        @(posedge CLK);
                        #1;
                        sub_if.sub_valid_res = 1'b0;
                    end else if (idx == glitch_k) begin
                        @(posedge CLK);
                        #1;
                        sub_if.sub_valid_res = 1'b0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        logic exp_busy;
        logic exp_done;
        logic exp_vin;
        if (RST && cyc == m_done) begin
            held_prod = pend_prod;
            held_err  = pend_err;
        end
        exp_busy = RST && (cyc > m_start) && (cyc <= m_done);
        exp_done = RST && (cyc == m_done);
        exp_vin  = 1'b0;
        for (int i = 0; i < 4; i++)
            if (RST && cyc == m_issue[i] && cyc <= m_done) exp_vin = 1'b1;
        check("cyc_busy",        32'(busy),                 32'(exp_busy));
        check("cyc_done",        32'(done),                 32'(exp_done));
        check("cyc_product",     32'(product),              32'(held_prod));
        check("cyc_timeout_err", 32'(timeout_err),          32'(held_err));
        check("cyc_valid_in",    32'(sub_if.sub_valid_in),  32'(exp_vin));
        check("cyc_sub_mode",    32'(sub_if.sub_mode),      32'(MODE));
        check("cyc_sub_op",      32'(sub_if.sub_op),        32'h0);
    end

    task automatic start_op(input logic [3:0] ia, input logic [3:0] ib, input logic md,
                            input int d0, input int d1, input int d2, input int d3,
                            input int gk, output longint s);
        longint t;
        int     dl [4];
        logic   aborted;
        dl = '{d0, d1, d2, d3};
        @(posedge CLK);
        #1;
        s          = cyc;
        resp_delay = dl;
        glitch_k   = gk;
        resp_idx   = 0;
        m_a        = ia;
        m_b        = ib;
        m_issue    = '{-10, -10, -10, -10};
        aborted    = 1'b0;
        t          = s + 1;
        for (int k = 0; k < 4; k++) begin
            m_issue[k] = t;
            if (dl[k] < 0) begin
                t += 1 + TO;
                aborted = 1'b1;
                break;
            end
            t += dl[k] + 2;
        end
        m_start   = s;
        m_done    = t;
        pend_prod = aborted ? 8'h00 : 8'(32'(ia) * 32'(ib));
        pend_err  = aborted;
        MODE      = md;
        a         = ia;
        b         = ib;
        start     = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int start_glitch_at, output longint dc);
        bit got;
        got = 1'b0;
        dc  = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (i == start_glitch_at) begin
                start = 1'b1;
                a     = 4'h1;
                b     = 4'h1;
            end else if (i == start_glitch_at + 1) begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                got = 1'b1;
                dc  = cyc;
                break;
            end
        end
        start = 1'b0;
        if (!got) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_done_wait: no done within 100 cycles, expected one", name);
        end
    endtask

    longint s;
    longint dc;

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_busy",    32'(busy),        32'h0);
        check("rst_done",    32'(done),        32'h0);
        check("rst_product", 32'(product),     32'h0);
        check("rst_sub_in1", 32'(sub_if.sub_in1), 32'h0);
        RST = 1'b1;

        // a=3, b=5, 3-cycle responder
        start_op(4'd3, 4'd5, 1'b0, 3, 3, 3, 3, -1, s);
        wait_done("t1", -1, dc);
        check("t1_product", 32'(product),     32'd15);
        check("t1_err",     32'(timeout_err), 32'd0);
        check("t1_pairs",   {24'h0, cap1[0], cap2[0], cap1[1], cap2[1]}, 32'b1101_0001);
        check("t1_pairs_hi",{24'h0, cap1[2], cap2[2], cap1[3], cap2[3]}, 32'b1101_0001);
        @(negedge CLK);
        check("t1_busy_after", 32'(busy), 32'd0);

        // a=15, b=15, immediate responder
        start_op(4'd15, 4'd15, 1'b1, 0, 0, 0, 0, -1, s);
        wait_done("t2", -1, dc);
        check("t2_product", 32'(product), 32'd225);
        check("t2_latency", 32'(dc - s),  32'd9);

        // a=0, b=9, then back-to-back a=2, b=7
        start_op(4'd0, 4'd9, 1'b0, 1, 0, 2, 0, -1, s);
        wait_done("t3a", -1, dc);
        check("t3a_product", 32'(product),  32'd0);
        check("t3a_requests", 32'(resp_idx), 32'd4);
        start_op(4'd2, 4'd7, 1'b1, 0, 1, 0, 1, -1, s);
        check("t3b_accept_cycle", 32'(s - dc), 32'd1);
        wait_done("t3b", -1, dc);
        check("t3b_product", 32'(product), 32'd14);

        // start while busy and sub_valid_res during ISSUE are ignored
        start_op(4'd10, 4'd13, 1'b0, 2, 2, 2, 2, 1, s);
        wait_done("t4", 3, dc);
        check("t4_product", 32'(product), 32'd130);
        check("t4_latency", 32'(dc - s),  32'd17);

        // no answer on k=1 -> abort after TO WAIT cycles
        start_op(4'd7, 4'd9, 1'b1, 0, -1, 0, 0, -1, s);
        wait_done("t5a", -1, dc);
        check("t5a_product", 32'(product),     32'd0);
        check("t5a_err",     32'(timeout_err), 32'd1);
        check("t5a_latency", 32'(dc - s),      32'd12);
        start_op(4'd4, 4'd3, 1'b0, 1, 0, 2, 1, -1, s);
        wait_done("t5b", -1, dc);
        check("t5b_product", 32'(product),     32'd12);
        check("t5b_err",     32'(timeout_err), 32'd0);

        // reset during WAIT of k=2
        start_op(4'd11, 4'd11, 1'b1, 0, 0, 5, 0, -1, s);
        while (cyc < s + 7) @(negedge CLK);
        #2;
        RST       = 1'b0;
        m_start   = -10;
        m_done    = -10;
        m_issue   = '{-10, -10, -10, -10};
        held_prod = 8'h00;
        held_err  = 1'b0;
        #1;
        check("t6_rst_busy",    32'(busy),                32'h0);
        check("t6_rst_product", 32'(product),             32'h0);
        check("t6_rst_err",     32'(timeout_err),         32'h0);
        check("t6_rst_vin",     32'(sub_if.sub_valid_in), 32'h0);
        check("t6_rst_in",      {28'h0, sub_if.sub_in1, sub_if.sub_in2}, 32'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (8) @(negedge CLK);
        start_op(4'd6, 4'd6, 1'b0, 1, 1, 1, 1, -1, s);
        wait_done("t6", -1, dc);
        check("t6_product", 32'(product), 32'd36);
        check("t6_latency", 32'(dc - s),  32'd13);
        repeat (2) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
